// File: rtl/pulse_separator_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_separator_if
// Description : Event handshake between an event source and pulse_separator.
//               master = event source, slave = pulse_separator.
// Revision    : 1.0  initial release
// ============================================================================
interface pulse_separator_if;
    logic pulse_in;   // one event per high cycle
    logic pulse_out;  // separated one-cycle pulses
    logic busy;       // pending counter near full, source must pause

    modport master (
        output pulse_in,
        input  pulse_out,
        input  busy
    );

    modport slave (
        input  pulse_in,
        output pulse_out,
        output busy
    );
endinterface : pulse_separator_if
`default_nettype wire

// File: rtl/pulse_separator.sv
`default_nettype none
// ============================================================================
// Module      : pulse_separator
// Description : Turns an arbitrary event pattern on pulse_in (one event per
//               high cycle) into one-cycle pulses on pulse_out separated by
//               at least one low cycle. Events that cannot be emitted yet are
//               held in a saturating pending counter; busy warns the source
//               one event before the counter saturates.
//               Optional macro PULSE_SEPARATOR_ASSERTIONS_EN compiles in
//               simulation-only checks for dropped events, back-to-back
//               output pulses and counter underflow.
// Revision    : 1.0  initial release
// ============================================================================
module pulse_separator #(
    parameter int PULSE_COUNTER_WIDTH = 4
) (
    input  logic               clock,
    input  logic               resetn,
    pulse_separator_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [PULSE_COUNTER_WIDTH-1:0] c_ZERO = '0;
    localparam logic [PULSE_COUNTER_WIDTH-1:0] c_ONE  =
        {{(PULSE_COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PULSE_COUNTER_WIDTH-1:0] c_MAX  = '1;
    // busy asserts one slot early so an event already in flight still fits
    localparam logic [PULSE_COUNTER_WIDTH-1:0] c_BUSY_LEVEL = c_MAX - c_ONE;

    // A one-bit counter leaves no room for the early busy warning
    if (PULSE_COUNTER_WIDTH < 2) begin : g_bad_width
        $error("pulse_separator: PULSE_COUNTER_WIDTH must be 2 or more");
    end

    // ------------------------------------------------------------------------
    // State and decision signals
    // ------------------------------------------------------------------------
    logic [PULSE_COUNTER_WIDTH-1:0] count_q;
    logic [PULSE_COUNTER_WIDTH-1:0] count_d;
    logic                           pulse_out_q;
    logic                           pulse_out_d;
    logic                           w_fire;
    logic                           w_accept;
    logic                           w_has_pending;
    logic                           w_busy;

    // Emit/accept decisions; an emit this cycle frees a slot for a new event
    always_comb begin
        w_has_pending = (count_q != c_ZERO);
        w_fire        = !pulse_out_q && (w_has_pending || bus.pulse_in);
        w_accept      = bus.pulse_in && ((count_q != c_MAX) || w_fire);
    end

    // Next-state: count moves by accepted minus emitted, pulse_out follows fire
    always_comb begin
        count_d     = count_q;
        pulse_out_d = w_fire;
        case ({w_accept, w_fire})
            2'b10:   count_d = count_q + c_ONE;
            2'b01:   count_d = count_q - c_ONE;
            default: count_d = count_q;   // idle, pass-through or balanced
        endcase
    end

    // State register; reset drops every pending event at once
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q     <= c_ZERO;
            pulse_out_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pulse_out_q <= pulse_out_d;
        end
    end

    // busy depends only on the registered count, never on pulse_in
    always_comb begin
        w_busy = (count_q >= c_BUSY_LEVEL);
    end

    assign bus.pulse_out = pulse_out_q;
    assign bus.busy      = w_busy;

`ifdef PULSE_SEPARATOR_ASSERTIONS_EN
    // Simulation-only sanity checks, sampled on the active edge
    always @(posedge clock) begin
        if (resetn) begin
            if (bus.pulse_in && !w_accept)
                $error("pulse_separator: event dropped, pending counter full");
            if (pulse_out_q && pulse_out_d)
                $error("pulse_separator: pulse_out high on consecutive cycles");
            if (w_fire && !w_accept && (count_q == c_ZERO))
                $error("pulse_separator: pending counter underflow");
        end
    end
`else
    // No checks in this build; behaviour is identical
`endif

endmodule : pulse_separator
`default_nettype wire

// File: tb/tb_pulse_separator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_separator
// Description : Self-checking bench for pulse_separator, width 3 (MAX = 7).
//               Table-driven cycle vectors plus hand-written sequences for
//               saturation, random traffic and reset during drain.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_separator;

    typedef struct {
        logic       pin;
        logic       exp_pout;
        logic       exp_busy;
        logic [2:0] exp_count;
    } vec_t;

    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    pulse_separator_if bus ();

    pulse_separator #(
        .PULSE_COUNTER_WIDTH (3)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one input cycle, then sample 1 time unit after the edge
    task automatic step(input logic pin);
        bus.pulse_in = pin;
        @(posedge clock);
        #1;
    endtask

    function automatic void add(input logic pin, input logic pout,
                                input logic busy, input logic [2:0] cnt);
        vec_t v;
        v.pin = pin; v.exp_pout = pout; v.exp_busy = busy; v.exp_count = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        int highs;
        int outs;
        int ins;
        logic prev;
        int dbl;
        n_cmp = 0;
        n_bad = 0;
        bus.pulse_in = 1'b0;
        resetn = 1'b0;

        // Single pulse: out 1 cycle after the sampling edge
        add(1, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
        // Wide pulse of 4: 1010101 then quiet
        add(1, 1, 0, 0); add(1, 0, 0, 1); add(1, 1, 0, 1); add(1, 0, 0, 2);
        add(0, 1, 0, 1); add(0, 0, 0, 1); add(0, 1, 0, 0); add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        // Alternating 1,0 x4: straight pass-through, count stays 0
        add(1, 1, 0, 0); add(0, 0, 0, 0); add(1, 1, 0, 0); add(0, 0, 0, 0);
        add(1, 1, 0, 0); add(0, 0, 0, 0); add(1, 1, 0, 0); add(0, 0, 0, 0);

        // Reset values while resetn is low
        #12;
        check("reset_pulse_out", int'(bus.pulse_out), 0);
        check("reset_busy",      int'(bus.busy),      0);
        check("reset_count",     int'(dut.count_q),   0);
        @(negedge clock);
        resetn = 1'b1;

        // Table-driven cycles
        foreach (vecs[i]) begin
            step(vecs[i].pin);
            check($sformatf("vec%0d_pulse_out", i), int'(bus.pulse_out), int'(vecs[i].exp_pout));
            check($sformatf("vec%0d_busy", i),      int'(bus.busy),      int'(vecs[i].exp_busy));
            check($sformatf("vec%0d_count", i),     int'(dut.count_q),   int'(vecs[i].exp_count));
        end

        // Saturation: hold high until busy is seen, then drop
        highs = 0; outs = 0; dbl = 0; prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1);
            highs++;
            outs += int'(bus.pulse_out);
            if (prev && bus.pulse_out) dbl++;
            prev = bus.pulse_out;
            if (bus.busy) break;
        end
        check("sat_highs_until_busy", highs, 12);
        check("sat_count_at_busy", int'(dut.count_q), 6);
        step(1'b0);
        outs += int'(bus.pulse_out);
        if (prev && bus.pulse_out) dbl++;
        prev = bus.pulse_out;
        check("sat_busy_falls", int'(bus.busy), 0);
        check("sat_count_after_drop", int'(dut.count_q), 5);
        for (int c = 0; c < 20; c++) begin
            step(1'b0);
            outs += int'(bus.pulse_out);
            if (prev && bus.pulse_out) dbl++;
            prev = bus.pulse_out;
        end
        check("sat_total_pulses", outs, 12);
        check("sat_back_to_back", dbl, 0);
        check("sat_count_drained", int'(dut.count_q), 0);

        // Random traffic gated by busy
        ins = 0; outs = 0; dbl = 0; prev = bus.pulse_out;
        for (int c = 0; c < 100; c++) begin
            logic p;
            p = !bus.busy && ($urandom_range(2) == 0);
            step(p);
            ins += int'(p);
            outs += int'(bus.pulse_out);
            if (prev && bus.pulse_out) dbl++;
            prev = bus.pulse_out;
        end
        for (int c = 0; c < 30; c++) begin
            step(1'b0);
            outs += int'(bus.pulse_out);
            if (prev && bus.pulse_out) dbl++;
            prev = bus.pulse_out;
        end
        check("rand_conserved", outs, ins);
        check("rand_back_to_back", dbl, 0);
        check("rand_count_drained", int'(dut.count_q), 0);

        // Reset mid-drain with count = 4 and pulse_out high
        for (int c = 0; c < 9; c++) step(1'b1);
        check("rst_pre_count", int'(dut.count_q), 4);
        check("rst_pre_pulse_out", int'(bus.pulse_out), 1);
        bus.pulse_in = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_pulse_out", int'(bus.pulse_out), 0);
        check("rst_async_busy",      int'(bus.busy),      0);
        check("rst_async_count",     int'(dut.count_q),   0);
        @(negedge clock);
        resetn = 1'b1;
        outs = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0);
            outs += int'(bus.pulse_out);
        end
        check("rst_no_pulses_after", outs, 0);
        check("rst_count_after", int'(dut.count_q), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pulse_separator
`default_nettype wire

// File: doc/pulse_separator.md
# pulse_separator

Converts an arbitrary pattern on a single-bit pulse input into a stream of one-cycle output pulses separated by at least one low cycle. Every clock cycle in which `pulse_in` is high counts as one event, and each event produces exactly one `pulse_out` pulse. Events that cannot be emitted yet wait in a saturating pending-event counter. The block sits between an event source that may assert back-to-back or wide pulses and a consumer that needs discrete, edge-separated pulses, such as a clock-domain pulse synchronizer or an edge-counting peripheral.

## Interface
- `PULSE_COUNTER_WIDTH`, default 4: width of the pending-event counter. Legal range is 2 or more. Counter maximum `MAX = 2**PULSE_COUNTER_WIDTH - 1`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `pulse_in`  in  1  event input; each high cycle is one event.
- `pulse_out`  out  1  registered output; one-cycle pulses with at least one low cycle between pulses.
- `busy`  out  1  pending counter is near full; the upstream source must stop issuing events.

## Operation
- State: `count` (PULSE_COUNTER_WIDTH bits, unsigned) and the `pulse_out` register.
- Emit decision, combinational: `fire = !pulse_out && (count != 0 || pulse_in)`.
- Accept decision: `accept = pulse_in && (count < MAX || fire)`.
- Register updates on each rising edge:
  - `pulse_out <= fire`
  - `count <= count + accept - fire`
- Pass-through: when `count == 0`, `pulse_in = 1` and `pulse_out = 0`, the event is emitted directly and `count` stays 0.
- Since `fire` requires `pulse_out == 0`, `pulse_out` is never high for two consecutive cycles.
- When `count != 0`, `pulse_out` toggles 1,0,1,0 until the counter drains. The drain rate is one event per two cycles.
- `busy = (count >= MAX - 1)`, combinational from `count`.
  - One further event arriving in a cycle where `busy` is high is still absorbed.
  - A source that drops `pulse_in` on the first `busy` cycle therefore loses no events.
- Overflow: if `count == MAX`, `pulse_in = 1` and `fire = 0`, the event is dropped and `count` stays at `MAX`. There is no wrap-around.
- Simultaneous accept and fire leave `count` unchanged, including at `MAX`.
- Events are conserved: output pulse count equals accepted input events.

## Timing
- Reset values, with `resetn` low, applied asynchronously: `count = 0`, `pulse_out = 0`, `busy = 0`.
- Reset asserted mid-operation discards all pending events immediately. No pulse follows deassertion unless new input arrives.
- Latency: an event sampled at rising edge N with the block idle drives `pulse_out` high for the cycle following edge N, i.e. 1 cycle.
- `pulse_in` held high for L cycles from idle, with `busy` never reached, gives L output pulses on alternating cycles. The last pulse appears around 2L cycles after the first edge.
- With `pulse_in` held continuously high, `count` grows by 1 every two cycles. For PULSE_COUNTER_WIDTH=3, `busy` rises after the 12th sampled high cycle (`count = 6`).
- `busy` changes only after a rising edge. It has no combinational path from `pulse_in`.

## Configuration
- Macro `PULSE_SEPARATOR_ASSERTIONS_EN`.
- Defined: simulation-only checks are compiled in.
  - An error is reported when an event is dropped on overflow.
  - An error is reported if `pulse_out` is high on two consecutive cycles.
  - An error is reported if `count` would underflow.
- Undefined: no checks; RTL behaviour is identical.

## Test plan
All scenarios use PULSE_COUNTER_WIDTH=3 and start after reset release.
- Single pulse: `pulse_in` high for 1 cycle -> exactly 1 `pulse_out` pulse, 1 cycle wide, high on the cycle after the sampling edge; `busy` stays 0.
- Wide pulse: `pulse_in` high for 4 cycles -> 4 one-cycle pulses with 1-cycle gaps (1010101), first pulse 1 cycle after the first sampled edge, then `pulse_out` stays 0.
- Alternating input: pattern 1,0 repeated 4 times -> 4 output pulses, each 1 cycle after its input; `count` stays 0.
- Saturation: `pulse_in` held high until `busy` is seen, then dropped -> `busy` after 12 high cycles; exactly 12 output pulses, all one-cycle with single gaps; `count` returns to 0 and `busy` falls when `count` drops below 6.
- Random: 100 cycles with `pulse_in` random (about 1/3 high) and gated by `!busy` -> total output pulses equal total input high cycles; never two consecutive high output cycles.
- Reset mid-drain: assert `resetn` low while `count = 4` -> `pulse_out`, `busy` and `count` at 0 immediately; no pulses after release.
